mem_bridge: RTL

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge_pkg.sv | 35 +++
 rtl/mem_bridge_if.sv | 27 ++
 rtl/mem_wbuf.sv | 102 ++++++++++
 rtl/mem_bridge.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the core-to-memory bridge: FSM states, access decode, parameter defaults.
// No logic of its own; imported by the interface, the write buffer and the bridge top.
package mem_bridge_pkg;

  localparam int WB_DEPTH_DEF = 4;
  localparam int ADDR_W_DEF   = 7;
  localparam int DATA_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_WR,
    ACC_RD
  } acc_t;

  // Core strobes are active-low; a write wins when WEN and OEN are both asserted.
  function automatic acc_t decode_acc(input logic cen, input logic wen, input logic oen);
    acc_t acc;
    acc = ACC_NONE;
    if (!cen && !wen) begin
      acc = ACC_WR;
    end else if (!cen && !oen) begin
      acc = ACC_RD;
    end
    return acc;
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// External memory request/response bus: one registered request, ready-accepted, read data on rvalid.
// master drives the request side, slave (the memory) drives ready and the read response.
interface mem_bridge_if
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_wbuf.sv
// Circular write buffer with per-entry valid bits; push/pop take effect at the clock edge.
// Lookup is combinational and returns the youngest valid entry matching the address.
module mem_wbuf
  import mem_bridge_pkg::*;
#(
  parameter int  DEPTH  = WB_DEPTH_DEF,
  parameter int  ADDR_W = ADDR_W_DEF,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] next_addr,
  output logic [DATA_W-1:0] next_data,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_nxt;
  logic [PTR_W-1:0]  idx;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Walk from oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (vld_q[idx] && (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign rd_nxt    = rd_ptr_q + PTR_W'(1);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign next_addr = addr_q[rd_nxt];
  assign next_data = data_q[rd_nxt];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/mem_bridge.sv
// Core SRAM-style port to external memory: writes are posted through mem_wbuf, read hits bypass,
// read misses stall the core for 3 cycles plus memory wait states; one memory transaction at a time.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int  WB_DEPTH = WB_DEPTH_DEF,
  parameter int  ADDR_W   = ADDR_W_DEF,
  localparam int CNT_W    = $clog2(WB_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  output logic              stall,
  mem_bridge_if.master      mem
);

  acc_t              acc;
  logic              core_wr, core_rd, rd_miss;
  logic              push, pop;
  logic [CNT_W-1:0]  wb_count;
  logic              wb_full, wb_empty, wb_hit;
  logic [ADDR_W-1:0] head_addr, next_addr;
  logic [DATA_W-1:0] head_data, next_data, hit_data;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  assign acc     = decode_acc(CEN, WEN, OEN);
  assign core_wr = (acc == ACC_WR);
  assign core_rd = (acc == ACC_RD);
  assign push    = core_wr && !wb_full;
  assign rd_miss = core_rd && !wb_hit;

  mem_wbuf #(
    .DEPTH  (WB_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (A),
    .push_data   (Data2Mem),
    .pop         (pop),
    .lookup_addr (A),
    .count       (wb_count),
    .full        (wb_full),
    .empty       (wb_empty),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .next_addr   (next_addr),
    .next_data   (next_data),
    .hit         (wb_hit),
    .hit_data    (hit_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_miss) begin
          state_d    = RD_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = A;
        end else if (!wb_empty) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end
      end
      DRAIN: begin
        if (mem.mem_ready) begin
          pop = 1'b1;
          if (rd_miss) begin
            state_d    = RD_REQ;
            mem_we_d   = 1'b0;
            mem_addr_d = A;
          end else if (wb_count > CNT_W'(1)) begin
            mem_addr_d  = next_addr;
            mem_wdata_d = next_data;
          end else if (push) begin
            // Last entry leaves as a new one lands in the slot right behind it.
            mem_addr_d  = A;
            mem_wdata_d = Data2Mem;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end
      end
      RD_REQ: begin
        if (mem.mem_ready) begin
          state_d   = RD_WAIT;
          mem_req_d = 1'b0;
        end
      end
      RD_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = RD_DONE;
          hold_d  = mem.mem_rdata;
        end
      end
      RD_DONE: begin
        if (!wb_empty) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
    end
  end

  // Full comes from the registered count, so a pop in the same cycle still stalls the write.
  assign stall       = (core_wr && wb_full) || (rd_miss && (state_q != RD_DONE));
  assign ReadDataMem = (state_q == RD_DONE)  ? hold_q   :
                       (core_rd && wb_hit)   ? hit_data : '0;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
